axi4_lite_waitstate_slave: RTL and testbench
============================================

AXI4_LITE_WAITSTATE_SLAVE -- requirements
Module: axi4_lite_waitstate_slave

Interface
REQ-001 The block SHALL have these parameters:
- C_S_AXI_ADDR_WIDTH, 4, address width.
- C_S_AXI_DATA_WIDTH, 32, data width.
- AW_WAIT, 0, extra cycles before AWREADY.
- W_WAIT, 0, extra cycles before WREADY.
- B_WAIT, 0, cycles from write commit to BVALID.
- AR_WAIT, 0, extra cycles before ARREADY.
- R_WAIT, 0, cycles from AR handshake to RVALID.
- All WAIT values are in the range 0..255.
REQ-002 The block SHALL have these ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  reset; one clock, reset synchronous and active-low.
- S_AXI_AWADDR  in  ADDR_WIDTH; S_AXI_AWPROT  in  3  (ignored); S_AXI_AWVALID  in  1; S_AXI_AWREADY  out  1.
- S_AXI_WDATA  in  32; S_AXI_WSTRB  in  4; S_AXI_WVALID  in  1; S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1.
- S_AXI_ARADDR  in  ADDR_WIDTH; S_AXI_ARPROT  in  3  (ignored); S_AXI_ARVALID  in  1; S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  32; S_AXI_RRESP  out  2; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1.
- decerr_cnt  out  8  saturating count of DECERR responses.

Function
REQ-003 The block SHALL hold four 32-bit registers at byte offsets 0x0, 0x4, 0x8, 0xC, decoded from ADDR[3:2].
REQ-004 The block SHALL treat an address as invalid when ADDR[1:0]!=0; invalid accesses SHALL get DECERR (2'b11).
REQ-005 The write FSM SHALL have states W_IDLE, W_COLLECT, W_DELAY, W_RESP.
REQ-006 In W_IDLE/W_COLLECT, AW and W SHALL be accepted independently and in either order, each with its own wait counter.
REQ-007 Each wait counter SHALL increment on every cycle its VALID is high and its beat is not yet captured.
REQ-008 READY (registered) SHALL assert the cycle after the counter equals its WAIT value.
REQ-009 READY SHALL stay high until the handshake, then drop on the next edge.
REQ-010 The minimum VALID-to-handshake latency SHALL be WAIT+1 cycles.
REQ-011 After a channel is captured, its READY SHALL stay low until the write returns to W_IDLE.
REQ-012 The write SHALL commit on the first edge after both AW and W are captured (W_COLLECT->W_DELAY).
REQ-013 The commit SHALL update only the byte lanes with WSTRB=1, and SHALL write nothing if the address is invalid.
REQ-014 W_DELAY SHALL last B_WAIT cycles; the block SHALL then enter W_RESP with BVALID=1, BRESP=00 or 11.
REQ-015 BVALID and BRESP SHALL stay stable until BREADY=1; the block SHALL then drop BVALID and return to W_IDLE on the next edge.
REQ-016 The read FSM SHALL have states R_IDLE, R_DELAY, R_RESP.
REQ-017 ARREADY SHALL follow the same wait rule as AW, using AR_WAIT.
REQ-018 The read FSM SHALL sample RDATA on the AR handshake edge: the register value, or 0xDEADDEAD for an invalid address.
REQ-019 After R_WAIT cycles, RVALID, RDATA and RRESP SHALL assert and stay stable until RREADY=1; the FSM SHALL then return to R_IDLE.
REQ-020 ARREADY SHALL stay low from the AR handshake until the return to R_IDLE.
REQ-021 The read and write paths SHALL run concurrently.
REQ-022 If the AR handshake and a write commit to the same register fall on the same edge, the read SHALL return the pre-write value.
REQ-023 decerr_cnt SHALL increment by 1 for each DECERR B or R handshake, by 2 when both occur on one edge, and saturate at 255.
REQ-024 Each channel SHALL allow at most one outstanding transaction.

Reset
REQ-025 While S_AXI_ARESETN=0 at an edge, the block SHALL clear all registers, decerr_cnt, wait counters and capture flags, and SHALL put both FSMs in IDLE.
REQ-026 At that edge all READY/VALID outputs SHALL go to 0 and BRESP/RRESP/RDATA to 0.
REQ-027 A reset mid-transaction SHALL drop the transaction with no response and no partial register write.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- All WAIT=0: write 0x4 = 0x11223344, strb 1111 -> AWREADY/WREADY one cycle after VALID, BVALID 1 cycle after commit, BRESP=00; read 0x4 -> 0x11223344, RRESP=00.
- AW_WAIT=5, W_WAIT=0, W presented 3 cycles before AW -> WREADY handshake first, AW handshake 6 cycles after AWVALID, single commit, BRESP=00.
- Reg 0x8=0, write 0xFFFFFFFF strb 0101 -> read 0x8 returns 0x00FF00FF.
- Write 0x5 -> BRESP=11, registers unchanged; read 0x6 -> RDATA=0xDEADDEAD, RRESP=11; decerr_cnt=2.
- B_WAIT=3, R_WAIT=4, BREADY/RREADY held low 10 cycles -> BVALID/RVALID and response fields stable throughout; each handshake completes in the cycle READY rises.
- Reset asserted in W_DELAY -> BVALID never rises, all registers read 0 after reset, 300 further decerr events -> decerr_cnt=255.

Source files
------------

// File: rtl/axi4_lite_waitstate_slave.sv
// AXI4-Lite slave with four 32-bit registers and parameterised wait states on every channel.
// Read and write paths are independent; decerr_cnt counts DECERR response handshakes.
module axi4_lite_waitstate_slave #(
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int AW_WAIT            = 0,
   parameter int W_WAIT             = 0,
   parameter int B_WAIT             = 0,
   parameter int AR_WAIT            = 0,
   parameter int R_WAIT             = 0
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic [7:0]                        decerr_cnt
);

   localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
   localparam logic [C_S_AXI_DATA_WIDTH-1:0] DEC_DATA = C_S_AXI_DATA_WIDTH'(32'hDEADDEAD);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_DELAY, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_DELAY, R_RESP} r_state_t;

   function automatic logic addr_ok(input logic [C_S_AXI_ADDR_WIDTH-1:0] a);
      return a[1:0] == 2'b00;
   endfunction

   function automatic logic [7:0] wait_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   function automatic logic [7:0] sat_add(input logic [7:0] c, input logic [1:0] n);
      logic [8:0] s;
      s = {1'b0, c} + {7'b0, n};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   w_state_t                          w_state_q, w_state_d;
   r_state_t                          r_state_q, r_state_d;
   logic [7:0]                        aw_cnt_q, aw_cnt_d, w_cnt_q, w_cnt_d, ar_cnt_q, ar_cnt_d;
   logic [7:0]                        b_cnt_q, b_cnt_d, r_cnt_q, r_cnt_d;
   logic                              awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
   logic                              aw_cap_q, aw_cap_d, w_cap_q, w_cap_d;
   logic [C_S_AXI_ADDR_WIDTH-1:0]     aw_addr_q, aw_addr_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic [STRB_W-1:0]                 wstrb_q, wstrb_d;
   logic                              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
   logic [1:0]                        bresp_q, bresp_d, rresp_q, rresp_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]     rdata_q, rdata_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]     regs_q [4];
   logic [C_S_AXI_DATA_WIDTH-1:0]     regs_d [4];
   logic [7:0]                        decerr_q, decerr_d;
   logic                              aw_hs, w_hs, ar_hs, b_dec, r_dec;
   logic                              unused_prot;

   assign aw_hs = awready_q && S_AXI_AWVALID;
   assign w_hs  = wready_q && S_AXI_WVALID;
   assign ar_hs = arready_q && S_AXI_ARVALID;
   assign b_dec = bvalid_q && S_AXI_BREADY && (bresp_q == RESP_DECERR);
   assign r_dec = rvalid_q && S_AXI_RREADY && (rresp_q == RESP_DECERR);
   assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

   always_comb begin
      w_state_d = w_state_q;
      aw_cnt_d  = aw_cnt_q;
      w_cnt_d   = w_cnt_q;
      b_cnt_d   = b_cnt_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      aw_cap_d  = aw_cap_q;
      w_cap_d   = w_cap_q;
      aw_addr_d = aw_addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      regs_d    = regs_q;
      case (w_state_q)
         W_IDLE, W_COLLECT: begin
            if (aw_cap_q && w_cap_q) begin
               // Commit edge: both beats were captured on an earlier edge.
               if (addr_ok(aw_addr_q)) begin
                  for (int b = 0; b < STRB_W; b++)
                     if (wstrb_q[b]) regs_d[aw_addr_q[3:2]][8*b +: 8] = wdata_q[8*b +: 8];
                  bresp_d = RESP_OKAY;
               end else begin
                  bresp_d = RESP_DECERR;
               end
               b_cnt_d = '0;
               if (B_WAIT == 0) begin
                  w_state_d = W_RESP;
                  bvalid_d  = 1'b1;
               end else begin
                  w_state_d = W_DELAY;
               end
            end else begin
               if (!aw_cap_q) begin
                  if (aw_hs) begin
                     aw_cap_d  = 1'b1;
                     aw_addr_d = S_AXI_AWADDR;
                     awready_d = 1'b0;
                     aw_cnt_d  = '0;
                  end else if (!awready_q && S_AXI_AWVALID) begin
                     awready_d = (aw_cnt_q == 8'(AW_WAIT));
                     aw_cnt_d  = wait_inc(aw_cnt_q);
                  end
               end
               if (!w_cap_q) begin
                  if (w_hs) begin
                     w_cap_d  = 1'b1;
                     wdata_d  = S_AXI_WDATA;
                     wstrb_d  = S_AXI_WSTRB;
                     wready_d = 1'b0;
                     w_cnt_d  = '0;
                  end else if (!wready_q && S_AXI_WVALID) begin
                     wready_d = (w_cnt_q == 8'(W_WAIT));
                     w_cnt_d  = wait_inc(w_cnt_q);
                  end
               end
               w_state_d = (aw_cap_d || w_cap_d) ? W_COLLECT : W_IDLE;
            end
         end
         W_DELAY: begin
            if (b_cnt_q == 8'(B_WAIT - 1)) begin
               w_state_d = W_RESP;
               bvalid_d  = 1'b1;
            end else begin
               b_cnt_d = b_cnt_q + 8'd1;
            end
         end
         W_RESP: begin
            if (S_AXI_BREADY) begin
               bvalid_d  = 1'b0;
               aw_cap_d  = 1'b0;
               w_cap_d   = 1'b0;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      ar_cnt_d  = ar_cnt_q;
      r_cnt_d   = r_cnt_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      case (r_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               // regs_q is the pre-commit value when a write commits on this same edge.
               arready_d = 1'b0;
               ar_cnt_d  = '0;
               r_cnt_d   = '0;
               rdata_d   = addr_ok(S_AXI_ARADDR) ? regs_q[S_AXI_ARADDR[3:2]] : DEC_DATA;
               rresp_d   = addr_ok(S_AXI_ARADDR) ? RESP_OKAY : RESP_DECERR;
               if (R_WAIT == 0) begin
                  r_state_d = R_RESP;
                  rvalid_d  = 1'b1;
               end else begin
                  r_state_d = R_DELAY;
               end
            end else if (!arready_q && S_AXI_ARVALID) begin
               arready_d = (ar_cnt_q == 8'(AR_WAIT));
               ar_cnt_d  = wait_inc(ar_cnt_q);
            end
         end
         R_DELAY: begin
            if (r_cnt_q == 8'(R_WAIT - 1)) begin
               r_state_d = R_RESP;
               rvalid_d  = 1'b1;
            end else begin
               r_cnt_d = r_cnt_q + 8'd1;
            end
         end
         R_RESP: begin
            if (S_AXI_RREADY) begin
               rvalid_d  = 1'b0;
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      decerr_d = sat_add(decerr_q, {1'b0, b_dec} + {1'b0, r_dec});
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         aw_cnt_q  <= '0;
         w_cnt_q   <= '0;
         ar_cnt_q  <= '0;
         b_cnt_q   <= '0;
         r_cnt_q   <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         arready_q <= 1'b0;
         aw_cap_q  <= 1'b0;
         w_cap_q   <= 1'b0;
         aw_addr_q <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= '0;
         rvalid_q  <= 1'b0;
         rresp_q   <= '0;
         rdata_q   <= '0;
         decerr_q  <= '0;
         for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         aw_cnt_q  <= aw_cnt_d;
         w_cnt_q   <= w_cnt_d;
         ar_cnt_q  <= ar_cnt_d;
         b_cnt_q   <= b_cnt_d;
         r_cnt_q   <= r_cnt_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         arready_q <= arready_d;
         aw_cap_q  <= aw_cap_d;
         w_cap_q   <= w_cap_d;
         aw_addr_q <= aw_addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         decerr_q  <= decerr_d;
         for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RRESP   = rresp_q;
   assign S_AXI_RDATA   = rdata_q;
   assign decerr_cnt    = decerr_q;

endmodule

// File: tb/tb_axi4_lite_waitstate_slave.sv
// Bench for axi4_lite_waitstate_slave: one instance with no wait states, one with
// AW=5/W=0/B=3/AR=2/R=4, checked against a register-array and latency model.
module tb_axi4_lite_waitstate_slave;

   logic        clk;
   int          cyc = 0;
   int          checks = 0;
   int          passes = 0;

   logic        rstn    [2];
   logic [3:0]  awaddr  [2];
   logic [2:0]  awprot  [2];
   logic        awvalid [2];
   logic        awready [2];
   logic [31:0] wdata   [2];
   logic [3:0]  wstrb   [2];
   logic        wvalid  [2];
   logic        wready  [2];
   logic [1:0]  bresp   [2];
   logic        bvalid  [2];
   logic        bready  [2];
   logic [3:0]  araddr  [2];
   logic [2:0]  arprot  [2];
   logic        arvalid [2];
   logic        arready [2];
   logic [31:0] rdata   [2];
   logic [1:0]  rresp   [2];
   logic        rvalid  [2];
   logic        rready  [2];
   logic [7:0]  decerr  [2];

   int aw_wait [2] = '{0, 5};
   int w_wait  [2] = '{0, 0};
   int b_wait  [2] = '{0, 3};
   int ar_wait [2] = '{0, 2};
   int r_wait  [2] = '{0, 4};

   logic [31:0] mreg [2][4];
   int          mdec [2];

   axi4_lite_waitstate_slave u_dut0 (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn[0]),
      .S_AXI_AWADDR(awaddr[0]), .S_AXI_AWPROT(awprot[0]), .S_AXI_AWVALID(awvalid[0]), .S_AXI_AWREADY(awready[0]),
      .S_AXI_WDATA(wdata[0]), .S_AXI_WSTRB(wstrb[0]), .S_AXI_WVALID(wvalid[0]), .S_AXI_WREADY(wready[0]),
      .S_AXI_BRESP(bresp[0]), .S_AXI_BVALID(bvalid[0]), .S_AXI_BREADY(bready[0]),
      .S_AXI_ARADDR(araddr[0]), .S_AXI_ARPROT(arprot[0]), .S_AXI_ARVALID(arvalid[0]), .S_AXI_ARREADY(arready[0]),
      .S_AXI_RDATA(rdata[0]), .S_AXI_RRESP(rresp[0]), .S_AXI_RVALID(rvalid[0]), .S_AXI_RREADY(rready[0]),
      .decerr_cnt(decerr[0])
   );

   axi4_lite_waitstate_slave #(
      .AW_WAIT(5), .W_WAIT(0), .B_WAIT(3), .AR_WAIT(2), .R_WAIT(4)
   ) u_dut1 (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn[1]),
      .S_AXI_AWADDR(awaddr[1]), .S_AXI_AWPROT(awprot[1]), .S_AXI_AWVALID(awvalid[1]), .S_AXI_AWREADY(awready[1]),
      .S_AXI_WDATA(wdata[1]), .S_AXI_WSTRB(wstrb[1]), .S_AXI_WVALID(wvalid[1]), .S_AXI_WREADY(wready[1]),
      .S_AXI_BRESP(bresp[1]), .S_AXI_BVALID(bvalid[1]), .S_AXI_BREADY(bready[1]),
      .S_AXI_ARADDR(araddr[1]), .S_AXI_ARPROT(arprot[1]), .S_AXI_ARVALID(arvalid[1]), .S_AXI_ARREADY(arready[1]),
      .S_AXI_RDATA(rdata[1]), .S_AXI_RRESP(rresp[1]), .S_AXI_RVALID(rvalid[1]), .S_AXI_RREADY(rready[1]),
      .decerr_cnt(decerr[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input int s, input logic [3:0] a, input logic [31:0] d, input logic [3:0] st,
                           input int aw_dly, input int w_dly, input int br_dly,
                           output int hs_aw, output int hs_w);
      logic [1:0] exp_resp;
      int         t_aw, t_w, hmax, k;
      logic       stable;
      exp_resp = (a[1:0] == 2'b00) ? 2'b00 : 2'b11;
      hs_aw = -1;
      hs_w  = -1;
      t_aw  = 0;
      t_w   = 0;
      fork
         begin
            repeat (aw_dly) step();
            awaddr[s] = a; awvalid[s] = 1'b1; t_aw = cyc;
            for (int n = 0; n < 600 && hs_aw < 0; n++) begin
               if (awready[s]) hs_aw = cyc + 1;
               step();
            end
            awvalid[s] = 1'b0;
         end
         begin
            repeat (w_dly) step();
            wdata[s] = d; wstrb[s] = st; wvalid[s] = 1'b1; t_w = cyc;
            for (int n = 0; n < 600 && hs_w < 0; n++) begin
               if (wready[s]) hs_w = cyc + 1;
               step();
            end
            wvalid[s] = 1'b0;
         end
      join
      checks++;
      if (hs_aw - t_aw !== aw_wait[s] + 2)
         $display("FAIL aw_latency dut%0d: got %0d edges, want %0d", s, hs_aw - t_aw, aw_wait[s] + 2);
      else passes++;
      checks++;
      if (hs_w - t_w !== w_wait[s] + 2)
         $display("FAIL w_latency dut%0d: got %0d edges, want %0d", s, hs_w - t_w, w_wait[s] + 2);
      else passes++;
      hmax = (hs_aw > hs_w) ? hs_aw : hs_w;
      k = 0;
      while (!bvalid[s] && k < 600) begin step(); k++; end
      checks++;
      if (bvalid[s] !== 1'b1 || cyc !== hmax + 1 + b_wait[s] || bresp[s] !== exp_resp)
         $display("FAIL bvalid_rise dut%0d: bvalid=%b edge=%0d bresp=%b, want bvalid=1 edge=%0d bresp=%b",
                  s, bvalid[s], cyc, bresp[s], hmax + 1 + b_wait[s], exp_resp);
      else passes++;
      stable = 1'b1;
      repeat (br_dly) begin
         step();
         if (bvalid[s] !== 1'b1 || bresp[s] !== exp_resp) stable = 1'b0;
      end
      checks++;
      if (stable !== 1'b1) $display("FAIL b_stable dut%0d: got %b, want 1", s, stable);
      else passes++;
      bready[s] = 1'b1;
      step();
      bready[s] = 1'b0;
      checks++;
      if (bvalid[s] !== 1'b0) $display("FAIL b_drop dut%0d: bvalid=%b, want 0", s, bvalid[s]);
      else passes++;
      if (exp_resp == 2'b00) begin
         for (int b = 0; b < 4; b++)
            if (st[b]) mreg[s][a[3:2]][8*b +: 8] = d[8*b +: 8];
      end else begin
         mdec[s] = (mdec[s] >= 255) ? 255 : mdec[s] + 1;
      end
      checks++;
      if (decerr[s] !== 8'(mdec[s])) $display("FAIL decerr_w dut%0d: got %0d, want %0d", s, decerr[s], mdec[s]);
      else passes++;
   endtask

   task automatic do_read(input int s, input logic [3:0] a, input int rr_dly,
                          output logic [31:0] got, output int hs_ar);
      logic [31:0] exp_d;
      logic [1:0]  exp_r;
      int          t_ar, k;
      logic        stable;
      exp_d = (a[1:0] == 2'b00) ? mreg[s][a[3:2]] : 32'hDEADDEAD;
      exp_r = (a[1:0] == 2'b00) ? 2'b00 : 2'b11;
      hs_ar = -1;
      araddr[s] = a; arvalid[s] = 1'b1; t_ar = cyc;
      for (int n = 0; n < 600 && hs_ar < 0; n++) begin
         if (arready[s]) hs_ar = cyc + 1;
         step();
      end
      arvalid[s] = 1'b0;
      checks++;
      if (hs_ar - t_ar !== ar_wait[s] + 2)
         $display("FAIL ar_latency dut%0d: got %0d edges, want %0d", s, hs_ar - t_ar, ar_wait[s] + 2);
      else passes++;
      k = 0;
      while (!rvalid[s] && k < 600) begin step(); k++; end
      got = rdata[s];
      checks++;
      if (rvalid[s] !== 1'b1 || cyc !== hs_ar + r_wait[s])
         $display("FAIL rvalid_rise dut%0d: rvalid=%b edge=%0d, want rvalid=1 edge=%0d", s, rvalid[s], cyc, hs_ar + r_wait[s]);
      else passes++;
      checks++;
      if (rdata[s] !== exp_d || rresp[s] !== exp_r)
         $display("FAIL rdata dut%0d addr=%h: got %h/%b, want %h/%b", s, a, rdata[s], rresp[s], exp_d, exp_r);
      else passes++;
      stable = 1'b1;
      repeat (rr_dly) begin
         step();
         if (rvalid[s] !== 1'b1 || rdata[s] !== exp_d || rresp[s] !== exp_r) stable = 1'b0;
      end
      checks++;
      if (stable !== 1'b1) $display("FAIL r_stable dut%0d: got %b, want 1", s, stable);
      else passes++;
      rready[s] = 1'b1;
      step();
      rready[s] = 1'b0;
      checks++;
      if (rvalid[s] !== 1'b0) $display("FAIL r_drop dut%0d: rvalid=%b, want 0", s, rvalid[s]);
      else passes++;
      if (exp_r == 2'b11) mdec[s] = (mdec[s] >= 255) ? 255 : mdec[s] + 1;
      checks++;
      if (decerr[s] !== 8'(mdec[s])) $display("FAIL decerr_r dut%0d: got %0d, want %0d", s, decerr[s], mdec[s]);
      else passes++;
   endtask

   task automatic test_reset();
      for (int s = 0; s < 2; s++) begin
         rstn[s] = 1'b0; awvalid[s] = 1'b0; wvalid[s] = 1'b0; bready[s] = 1'b0;
         arvalid[s] = 1'b0; rready[s] = 1'b0; awaddr[s] = '0; araddr[s] = '0;
         wdata[s] = '0; wstrb[s] = '0; awprot[s] = 3'($urandom); arprot[s] = 3'($urandom);
         mdec[s] = 0;
         for (int r = 0; r < 4; r++) mreg[s][r] = '0;
      end
      repeat (3) step();
      rstn[0] = 1'b1; rstn[1] = 1'b1;
      step();
      for (int s = 0; s < 2; s++) begin
         checks++;
         if ({awready[s], wready[s], bvalid[s], arready[s], rvalid[s], bresp[s], rresp[s], rdata[s], decerr[s]} !== '0)
            $display("FAIL reset_outputs dut%0d: rdy=%b%b%b%b%b resp=%b/%b rdata=%h dec=%0d, want all 0", s,
                     awready[s], wready[s], bvalid[s], arready[s], rvalid[s], bresp[s], rresp[s], rdata[s], decerr[s]);
         else passes++;
      end
   endtask

   task automatic test_basic();
      int h1, h2, h3;
      logic [31:0] got;
      do_write(0, 4'h4, 32'h11223344, 4'hF, 0, 0, 0, h1, h2);
      do_read(0, 4'h4, 0, got, h3);
      checks++;
      if (got !== 32'h11223344) $display("FAIL basic_read: got %h, want 11223344", got);
      else passes++;
   endtask

   task automatic test_aw_late();
      int h_aw, h_w, h3;
      logic [31:0] got, d;
      d = $urandom;
      do_write(1, 4'hC, d, 4'hF, 3, 0, 0, h_aw, h_w);
      checks++;
      if (!(h_w < h_aw)) $display("FAIL w_before_aw: w edge %0d, aw edge %0d", h_w, h_aw);
      else passes++;
      do_read(1, 4'hC, 0, got, h3);
      checks++;
      if (got !== d) $display("FAIL aw_late_read: got %h, want %h", got, d);
      else passes++;
   endtask

   task automatic test_strobe();
      int h1, h2, h3;
      logic [31:0] got;
      do_write(0, 4'h8, 32'h0, 4'hF, 0, 0, 0, h1, h2);
      do_write(0, 4'h8, 32'hFFFFFFFF, 4'b0101, 0, 0, 0, h1, h2);
      do_read(0, 4'h8, 0, got, h3);
      checks++;
      if (got !== 32'h00FF00FF) $display("FAIL strobe_read: got %h, want 00ff00ff", got);
      else passes++;
   endtask

   task automatic test_decerr();
      int h1, h2, h3, d0;
      logic [31:0] got;
      d0 = mdec[0];
      do_write(0, 4'h5, $urandom, 4'hF, 0, 0, 0, h1, h2);
      do_read(0, 4'h6, 0, got, h3);
      checks++;
      if (got !== 32'hDEADDEAD) $display("FAIL decerr_rdata: got %h, want deaddead", got);
      else passes++;
      checks++;
      if (decerr[0] !== 8'(d0 + 2)) $display("FAIL decerr_count: got %0d, want %0d", decerr[0], d0 + 2);
      else passes++;
      for (int r = 0; r < 4; r++) do_read(0, 4'(r * 4), 0, got, h3);
   endtask

   task automatic test_stall();
      int h1, h2, h3;
      logic [31:0] got;
      do_write(1, 4'h0, $urandom, 4'hF, 0, 0, 10, h1, h2);
      do_read(1, 4'h0, 10, got, h3);
      do_write(1, 4'h3, $urandom, 4'hF, 0, 2, 10, h1, h2);
      do_read(1, 4'h2, 10, got, h3);
   endtask

   task automatic test_concurrent();
      int h_aw, h_w, h_ar;
      logic [31:0] got, d;
      d = ~mreg[0][0];
      fork
         do_write(0, 4'h0, d, 4'hF, 0, 0, 0, h_aw, h_w);
         begin
            step();
            do_read(0, 4'h0, 0, got, h_ar);
         end
      join
      checks++;
      if (h_ar !== ((h_aw > h_w) ? h_aw : h_w) + 1)
         $display("FAIL concurrent_align: ar edge %0d, commit edge %0d", h_ar, ((h_aw > h_w) ? h_aw : h_w) + 1);
      else passes++;
      checks++;
      if (got !== ~d) $display("FAIL concurrent_prewrite: got %h, want %h", got, ~d);
      else passes++;
   endtask

   task automatic test_random();
      int h1, h2, h3, s;
      logic [31:0] got;
      for (int i = 0; i < 40; i++) begin
         s = $urandom_range(0, 1);
         if ($urandom_range(0, 1) == 1)
            do_write(s, 4'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), h1, h2);
         else
            do_read(s, 4'($urandom), $urandom_range(0, 3), got, h3);
      end
   endtask

   task automatic test_reset_mid();
      logic got_aw, got_w, a_hs, w_hs, never;
      int h3;
      logic [31:0] got;
      got_aw = 1'b0; got_w = 1'b0;
      awaddr[1] = 4'h4; wdata[1] = 32'hCAFEF00D; wstrb[1] = 4'hF;
      awvalid[1] = 1'b1; wvalid[1] = 1'b1;
      for (int k = 0; k < 50 && !(got_aw && got_w); k++) begin
         a_hs = awvalid[1] && awready[1];
         w_hs = wvalid[1] && wready[1];
         step();
         if (a_hs) begin awvalid[1] = 1'b0; got_aw = 1'b1; end
         if (w_hs) begin wvalid[1] = 1'b0; got_w = 1'b1; end
      end
      awvalid[1] = 1'b0; wvalid[1] = 1'b0;
      checks++;
      if (!(got_aw && got_w)) $display("FAIL mid_handshake: aw=%b w=%b, want both 1", got_aw, got_w);
      else passes++;
      step();
      step();
      rstn[1] = 1'b0;
      step();
      rstn[1] = 1'b1;
      mdec[1] = 0;
      for (int r = 0; r < 4; r++) mreg[1][r] = '0;
      never = 1'b1;
      repeat (12) begin
         if (bvalid[1] !== 1'b0) never = 1'b0;
         bready[1] = 1'b1;
         step();
      end
      bready[1] = 1'b0;
      checks++;
      if (never !== 1'b1) $display("FAIL mid_no_bvalid: bvalid rose after reset");
      else passes++;
      checks++;
      if (decerr[1] !== 8'd0) $display("FAIL mid_decerr_clear: got %0d, want 0", decerr[1]);
      else passes++;
      for (int r = 0; r < 4; r++) do_read(1, 4'(r * 4), 0, got, h3);
      for (int i = 0; i < 300; i++) do_read(1, 4'({2'(i), 2'(1 + (i % 3))}), 0, got, h3);
      checks++;
      if (decerr[1] !== 8'd255) $display("FAIL decerr_saturate: got %0d, want 255", decerr[1]);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_aw_late();
      test_strobe();
      test_decerr();
      test_stall();
      test_concurrent();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
